// File: rtl/pipe_dmem_responder.sv
// pipe_dmem_responder: fixed-latency data-memory slave for the MEM stage; stalls the pipe until ready.
module pipe_dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              mis_q;
    logic [AW-1:0]     idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [DEPTH];
    logic              done;
    logic              unused_addr;

    assign done        = (state == WAIT) && (cnt == 4'd0);
    assign stall       = ((state == IDLE) && req) || (state == WAIT);
    assign unused_addr = ^addr[31:AW+2];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    state   <= WAIT;
                    we_q    <= we;
                    idx_q   <= addr[AW+1:2];
                    wdata_q <= wdata;
                    mis_q   <= addr[1:0] != 2'd0;
                    cnt     <= 4'(LATENCY - 1);
                end
                WAIT: if (cnt == 4'd0) begin
                    state <= RESP;
                    ready <= 1'b1;
                    err   <= mis_q;
                    rdata <= (we_q || mis_q) ? 32'd0 : mem[idx_q];
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // gated by resetn so a reset landing on the completing edge discards the store
    always_ff @(posedge clock) begin
        if (resetn && done && we_q && !mis_q)
            mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_pipe_dmem_responder.sv
// tb_pipe_dmem_responder: scoreboard bench; LATENCY=2 instance for the main plan, LATENCY=1 for back-to-back.
module tb_pipe_dmem_responder;
    localparam int LAT_A = 2;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready, stall, err;
    logic        req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_b = 32'd0, wdata_b = 32'd0;
    logic [31:0] rdata_b;
    logic        ready_b, stall_b, err_b;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [32:0] sb [$];
    logic [32:0] sb_b [$];
    logic [31:0] mem_m [32];

    always #5 clock = ~clock;

    pipe_dmem_responder #(.DEPTH(32), .LATENCY(LAT_A)) dut_a (
        .clock(clock), .resetn(resetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .stall(stall), .err(err)
    );

    pipe_dmem_responder #(.DEPTH(32), .LATENCY(1)) dut_b (
        .clock(clock), .resetn(resetn), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ready(ready_b), .stall(stall_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // starts and ends just after a rising edge
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [32:0] e;
        logic        seen;
        int          cyc;
        e = 33'd0;
        sb.push_back({a[1:0] != 2'd0, (w || a[1:0] != 2'd0) ? 32'd0 : mem_m[a[6:2]]});
        if (w && a[1:0] == 2'd0) mem_m[a[6:2]] = d;
        req = 1'b1; we = w; addr = a; wdata = d;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (ready) begin
                seen = 1'b1;
                e = sb.pop_front();
                check("latency", 64'(cyc), 64'(LAT_A + 2));
                check("rdata", 64'(rdata), 64'(e[31:0]));
                check("err", 64'(err), 64'(e[32]));
                check("stall_resp", 64'(stall), 64'd0);
                @(posedge clock); #1;
                req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
            end else begin
                check("stall_wait", 64'(stall), 64'd1);
            end
        end
        check("ready_seen", 64'(seen), 64'd1);
        @(negedge clock);
        check("ready_once", 64'(ready), 64'd0);
        check("rdata_hold", 64'(rdata), 64'(e[31:0]));
        check("stall_idle", 64'(stall), 64'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        int pulses, last;
        logic [32:0] e;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("reset_quiet", {30'd0, stall, ready, err, rdata}, 64'd0);
        end
        @(posedge clock); #1;

        access(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0008, 32'd0);
        access(1'b1, 32'h0000_0004, 32'h0BAD_F00D);
        access(1'b0, 32'h0000_0006, 32'd0);
        access(1'b0, 32'h0000_0004, 32'd0);
        access(1'b1, 32'h0000_0005, 32'hFFFF_FFFF);
        access(1'b0, 32'h0000_0004, 32'd0);
        access(1'b1, 32'h0000_0080, 32'h1234_5678);
        access(1'b0, 32'h0000_0000, 32'd0);
        access(1'b1, 32'h0000_000C, 32'h1111_2222);

        // store aborted by reset during WAIT; model memory deliberately untouched
        req = 1'b1; we = 1'b1; addr = 32'h0000_000C; wdata = 32'hCAFE_0001;
        @(negedge clock);
        check("abort_stall_req", 64'(stall), 64'd1);
        @(posedge clock); #1;
        req = 1'b0; we = 1'b0; resetn = 1'b0;
        @(negedge clock);
        check("abort_stall_wait", 64'(stall), 64'd1);
        @(posedge clock); #1;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("abort_no_ready", {32'd0, stall, ready, err, rdata[28:0]}, 64'd0);
        end
        @(posedge clock); #1;
        access(1'b0, 32'h0000_000C, 32'd0);

        // LATENCY=1, req held: one store then three loads, ready every third cycle
        sb_b.push_back(33'd0);
        repeat (3) sb_b.push_back({1'b0, 32'h0000_0055});
        req_b = 1'b1; we_b = 1'b1; addr_b = 32'h0000_0004; wdata_b = 32'h0000_0055;
        pulses = 0; last = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            check("b_ready", 64'(ready_b), 64'(c % 3 == 2));
            check("b_stall", 64'(stall_b), 64'(c % 3 != 2));
            if (ready_b) begin
                e = sb_b.pop_front();
                check("b_rdata", 64'(rdata_b), 64'(e[31:0]));
                check("b_err", 64'(err_b), 64'(e[32]));
                if (last >= 0) check("b_gap", 64'(c - last), 64'd3);
                last = c;
                pulses++;
                we_b = 1'b0;
            end
        end
        @(posedge clock); #1;
        req_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("b_no_extra", {62'd0, ready_b, stall_b}, 64'd0);
        end
        check("b_pulses", 64'(pulses), 64'd4);
        check("sb_empty", 64'(sb.size() + sb_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
